// File: rtl/round_robin_distributor.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_distributor
// Purpose  : Fans one valid/ready input stream out to SIZE output channels in
//            round-robin order. Each channel owns a one-entry register buffer.
//            All outputs come from registers; write_ready depends only on
//            registered state and resetn, never on read_ready.
// Ports    : clock        - rising-edge clock
//            resetn       - synchronous, active-low reset
//            write_valid  - upstream beat valid
//            write_data   - upstream beat data [WIDTH]
//            write_ready  - a target buffer is available this cycle
//            read_valid   - per-channel buffer occupied [SIZE]
//            read_data    - packed per-channel data, channel i at [i*WIDTH +: WIDTH]
//            read_ready   - per-channel downstream ready [SIZE]
// Config   : ROUND_ROBIN_DISTRIBUTOR_STRICT_ORDER_EN
//              defined   -> strict rotation: the target is always the pointer
//                           and a busy channel stalls the input
//              undefined -> skip-full selection (first empty channel at or
//                           after the pointer, wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module round_robin_distributor #(
   parameter int WIDTH = 8,
   parameter int SIZE  = 4
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    write_valid,
   input  logic [WIDTH-1:0]        write_data,
   output logic                    write_ready,
   output logic [SIZE-1:0]         read_valid,
   output logic [SIZE*WIDTH-1:0]   read_data,
   input  logic [SIZE-1:0]         read_ready
);

   localparam int PTR_W = $clog2(SIZE);

   logic [PTR_W-1:0]      r_pointer;
   logic [SIZE-1:0]       r_valid;
   logic [SIZE*WIDTH-1:0] r_data;

   logic [PTR_W-1:0]      w_target;
   logic                  w_found;
   logic                  w_wr;
   logic [SIZE-1:0]       w_rd;

   // (base + offs) mod SIZE, valid for offs in [0, SIZE); SIZE need not be a
   // power of two, so the wrap is explicit rather than relying on overflow.
   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                 input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= SIZE) s = s - SIZE;
      return PTR_W'(s);
   endfunction

`ifdef ROUND_ROBIN_DISTRIBUTOR_STRICT_ORDER_EN
   // Strict rotation: only the pointed-to channel may accept.
   always_comb begin
      w_target = r_pointer;
      w_found  = ~r_valid[r_pointer];
   end
`else
   // Skip-full: first empty channel scanning upward from the pointer.
   // w_found doubles as "any buffer empty".
   always_comb begin
      w_target = r_pointer;
      w_found  = 1'b0;
      for (int k = 0; k < SIZE; k++) begin
         if (!w_found && !r_valid[wrap_idx(r_pointer, k)]) begin
            w_target = wrap_idx(r_pointer, k);
            w_found  = 1'b1;
         end
      end
   end
`endif

   assign write_ready = resetn & w_found;
   assign w_wr        = write_valid & write_ready;
   assign w_rd        = r_valid & read_ready;

   assign read_valid  = r_valid;
   assign read_data   = r_data;

   // The write target is always an empty buffer, so a read clear and a write
   // load never hit the same channel in one cycle; a drained channel becomes
   // eligible only on the following cycle.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_pointer <= '0;
         r_valid   <= '0;
         r_data    <= '0;
      end else begin
         if (w_wr) begin
            r_pointer <= wrap_idx(w_target, 1);
         end
         for (int i = 0; i < SIZE; i++) begin
            if (w_rd[i]) begin
               r_valid[i] <= 1'b0;
            end
            if (w_wr && (w_target == PTR_W'(i))) begin
               r_valid[i]                 <= 1'b1;
               r_data[i*WIDTH +: WIDTH]   <= write_data;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_round_robin_distributor.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_robin_distributor
// Purpose  : Directed, table-driven bench for round_robin_distributor with
//            WIDTH=8, SIZE=4, plus hand-written streaming and mid-operation
//            reset sequences. Follows ROUND_ROBIN_DISTRIBUTOR_STRICT_ORDER_EN
//            to select the expected behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_robin_distributor;

   localparam int WIDTH = 8;
   localparam int SIZE  = 4;

   logic        clock       = 1'b0;
   logic        resetn      = 1'b0;
   logic        write_valid = 1'b0;
   logic [7:0]  write_data  = '0;
   logic        write_ready;
   logic [3:0]  read_valid;
   logic [31:0] read_data;
   logic [3:0]  read_ready  = '0;

   always #5 clock = ~clock;

   round_robin_distributor #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .write_valid (write_valid),
      .write_data  (write_data),
      .write_ready (write_ready),
      .read_valid  (read_valid),
      .read_data   (read_data),
      .read_ready  (read_ready)
   );

   // Each record: inputs applied for one cycle, and the outputs expected in
   // that same cycle (i.e. the state left by the previous edges).
   typedef struct {
      logic        rn;
      logic        wv;
      logic [7:0]  wd;
      logic [3:0]  rr;
      logic        ewr;
      logic [3:0]  erv;
      logic [31:0] ed;
      logic [1:0]  ep;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic rn, input logic wv, input logic [7:0] wd,
                               input logic [3:0] rr, input logic ewr,
                               input logic [3:0] erv, input logic [31:0] ed,
                               input logic [1:0] ep);
      vec_t v;
      v.rn = rn; v.wv = wv; v.wd = wd; v.rr = rr;
      v.ewr = ewr; v.erv = erv; v.ed = ed; v.ep = ep;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply inputs just after a falling edge; sample 1 time unit later.
   task automatic drive(input logic rn, input logic wv, input logic [7:0] wd,
                        input logic [3:0] rr);
      @(negedge clock);
      resetn      = rn;
      write_valid = wv;
      write_data  = wd;
      read_ready  = rr;
      #1;
   endtask

   initial begin
      int ch;

      // ---------------- common: reset, fill, full, drain channel 2 --------
      //          rn  wv  wd     rr       ewr   erv      ed            ep
      tbl.push_back(mk(0, 0, 8'h00, 4'b0000, 1'b0, 4'b0000, 32'h00000000, 2'd0));
      tbl.push_back(mk(1, 0, 8'h00, 4'b0000, 1'b1, 4'b0000, 32'h00000000, 2'd0));
      tbl.push_back(mk(1, 1, 8'h10, 4'b0000, 1'b1, 4'b0000, 32'h00000000, 2'd0));
      tbl.push_back(mk(1, 1, 8'h11, 4'b0000, 1'b1, 4'b0001, 32'h00000010, 2'd1));
      tbl.push_back(mk(1, 1, 8'h12, 4'b0000, 1'b1, 4'b0011, 32'h00001110, 2'd2));
      tbl.push_back(mk(1, 1, 8'h13, 4'b0000, 1'b1, 4'b0111, 32'h00121110, 2'd3));
      tbl.push_back(mk(1, 1, 8'h14, 4'b0000, 1'b0, 4'b1111, 32'h13121110, 2'd0));
      tbl.push_back(mk(1, 1, 8'h14, 4'b0100, 1'b0, 4'b1111, 32'h13121110, 2'd0));
`ifdef ROUND_ROBIN_DISTRIBUTOR_STRICT_ORDER_EN
      // Pointer 0 is busy: input stalls although channel 2 is free.
      tbl.push_back(mk(1, 1, 8'h14, 4'b0000, 1'b0, 4'b1011, 32'h13121110, 2'd0));
      tbl.push_back(mk(1, 1, 8'h14, 4'b0001, 1'b0, 4'b1011, 32'h13121110, 2'd0));
      tbl.push_back(mk(1, 1, 8'h14, 4'b0000, 1'b1, 4'b1010, 32'h13121110, 2'd0));
      tbl.push_back(mk(1, 1, 8'hAA, 4'b0000, 1'b0, 4'b1011, 32'h13121114, 2'd1));
      tbl.push_back(mk(1, 1, 8'hAA, 4'b0010, 1'b0, 4'b1011, 32'h13121114, 2'd1));
      tbl.push_back(mk(1, 1, 8'hAA, 4'b0000, 1'b1, 4'b1001, 32'h13121114, 2'd1));
      tbl.push_back(mk(1, 0, 8'h00, 4'b0000, 1'b1, 4'b1011, 32'h1312AA14, 2'd2));
`else
      // Reopen: pending 0x14 lands in channel 2, pointer -> 3.
      tbl.push_back(mk(1, 1, 8'h14, 4'b0000, 1'b1, 4'b1011, 32'h13121110, 2'd0));
      tbl.push_back(mk(1, 0, 8'h00, 4'b1110, 1'b0, 4'b1111, 32'h13141110, 2'd3));
      // Wrap: target 3 gives pointer 0.
      tbl.push_back(mk(1, 1, 8'hCC, 4'b0000, 1'b1, 4'b0001, 32'h13141110, 2'd3));
      tbl.push_back(mk(1, 0, 8'h00, 4'b1000, 1'b1, 4'b1001, 32'hCC141110, 2'd0));
      // Skip full: pointer 0, channel 0 full -> 0xAA into channel 1, pointer 2.
      tbl.push_back(mk(1, 1, 8'hAA, 4'b0000, 1'b1, 4'b0001, 32'hCC141110, 2'd0));
      tbl.push_back(mk(1, 0, 8'h00, 4'b0000, 1'b1, 4'b0011, 32'hCC14AA10, 2'd2));
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rn, tbl[i].wv, tbl[i].wd, tbl[i].rr);
         chk($sformatf("v%0d write_ready", i), 32'(write_ready), 32'(tbl[i].ewr));
         chk($sformatf("v%0d read_valid", i),  32'(read_valid),  32'(tbl[i].erv));
         chk($sformatf("v%0d read_data", i),   read_data,        tbl[i].ed);
         chk($sformatf("v%0d pointer", i),     32'(dut.r_pointer), 32'(tbl[i].ep));
      end

      // ---------------- streaming: 12 beats, consumers always ready -------
      drive(0, 0, 8'h00, 4'b0000);
      for (int b = 0; b < 12; b++) begin
         drive(1, 1, 8'(b), 4'b1111);
         chk($sformatf("stream b%0d write_ready", b), 32'(write_ready), 32'd1);
         if (b > 0) begin
            ch = (b - 1) % 4;
            chk($sformatf("stream b%0d read_valid", b - 1), 32'(read_valid), 32'(1) << ch);
            chk($sformatf("stream b%0d data", b - 1), 32'(read_data[ch*8 +: 8]), 32'(b - 1));
         end
      end
      drive(1, 0, 8'h00, 4'b1111);
      chk("stream b11 read_valid", 32'(read_valid), 32'b1000);
      chk("stream b11 data", 32'(read_data[31:24]), 32'd11);
      drive(1, 0, 8'h00, 4'b1111);
      chk("stream drained", 32'(read_valid), 32'd0);

      // ---------------- reset mid-operation with 3 buffers full -----------
      drive(0, 0, 8'h00, 4'b0000);
      drive(1, 1, 8'h21, 4'b0000);
      drive(1, 1, 8'h22, 4'b0000);
      drive(1, 1, 8'h23, 4'b0000);
      drive(0, 0, 8'h00, 4'b0000);
      chk("midrst held valid", 32'(read_valid), 32'b0111);
      chk("midrst write_ready low", 32'(write_ready), 32'd0);
      drive(1, 1, 8'h55, 4'b0000);
      chk("midrst read_valid", 32'(read_valid), 32'd0);
      chk("midrst read_data", read_data, 32'd0);
      chk("midrst write_ready", 32'(write_ready), 32'd1);
      drive(1, 0, 8'h00, 4'b0000);
      chk("midrst next to ch0 valid", 32'(read_valid), 32'b0001);
      chk("midrst next to ch0 data", read_data, 32'h00000055);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/round_robin_distributor.md
# round_robin_distributor

Splits a single valid/ready input stream across `SIZE` output channels in round-robin order, each output backed by a one-entry register buffer. It is the dispatch-side counterpart of the round-robin arbiter: the arbiter merges many requesters into one grant, and this block fans one producer out to many consumers, e.g. work dispatch to parallel engines. All outputs are registered, and there is no combinational path from any `read_ready` to `write_ready`.

## Interface
Parameters:
- `WIDTH`, 8: data width in bits, ≥1.
- `SIZE`, 4: number of output channels, ≥2; pointer width is `$clog2(SIZE)`.

Ports:
- `clock`  in  1: single clock, rising edge.
- `resetn`  in  1: reset, synchronous and active-low.
- `write_valid`  in  1: upstream data valid.
- `write_data`  in  WIDTH: upstream data.
- `write_ready`  out  1: block can accept `write_data` this cycle.
- `read_valid`  out  SIZE: per-channel buffer holds data.
- `read_data`  out  SIZE×WIDTH: packed per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- `read_ready`  in  SIZE: per-channel downstream ready.

## Operation
- State:
  - `pointer` is the next-priority channel.
  - `buffer_valid[SIZE]` and `buffer_data[SIZE]` form the per-channel entries.
- `read_valid = buffer_valid`; `read_data = buffer_data`.
- Target selection: the first channel with `buffer_valid == 0`, searching from `pointer` upward and wrapping at SIZE-1 to 0.
- `write_ready = resetn && (any buffer empty)`. It depends on registered state only.
- Write transfer occurs when `write_valid && write_ready`:
  - The target buffer loads `write_data` and sets its valid flag.
  - `pointer` becomes `(target+1) mod SIZE`.
- Read transfer on channel i occurs when `read_valid[i] && read_ready[i]`; it clears `buffer_valid[i]`.
- Simultaneous write and read on the same full channel cannot happen: a full channel is never a target in the cycle it drains, and it becomes eligible the following cycle.
- Simultaneous reads on several channels are independent; all of them clear in the same cycle.
- Data loaded in a channel is held stable while `read_valid[i]` is high and `read_ready[i]` is low.
- Pointer update:
  - `pointer` moves only on a write transfer.
  - Reads never move it.
  - With no write transfer, `pointer` holds.

## Timing
- Reset, sampled on the rising edge while `resetn` is 0:
  - `pointer = 0`, `buffer_valid = 0`, `buffer_data = 0`.
  - As a result, `read_valid = 0`, `read_data = 0`, and `write_ready = 0` while `resetn` is low.
- `write_ready = 1` from the first cycle with `resetn` high.
- Reset asserted mid-operation drops every buffered entry without further handshakes.
- Latency: data accepted at edge N is presented with `read_valid` high in the cycle following edge N, i.e. one cycle.
- Throughput:
  - One write per cycle while any buffer is empty.
  - With all consumers always ready, channels fill in order 0,1,…,SIZE-1,0,….
- Full condition: all `buffer_valid` are 1, so `write_ready = 0`. A freed buffer re-enables `write_ready` one cycle after its read transfer.
- Wrap-around: a target or pointer at SIZE-1 gives a next pointer of 0.

## Configuration
- Macro `ROUND_ROBIN_DISTRIBUTOR_STRICT_ORDER_EN`.
- Defined (strict rotation):
  - The target is always `pointer`.
  - `write_ready = resetn && !buffer_valid[pointer]`.
  - A busy channel stalls the input and is never skipped.
  - `pointer` increments modulo SIZE on each write transfer.
  - This guarantees that consumer k receives items k, k+SIZE, k+2·SIZE, ….
- Undefined (default): skip-full selection as described in Operation, for maximum throughput.

## Test plan
All scenarios use WIDTH=8, SIZE=4.
- Reset and fill: after reset, hold `read_ready = 0000` and write 0x10, 0x11, 0x12, 0x13.
  - Channels 0..3 hold 0x10..0x13 respectively, with `read_valid = 1111`.
  - `write_ready = 0` in the cycle after the 4th write.
  - A 5th beat 0x14 stays pending.
- Drain reopen: from the full state, pulse `read_ready = 0100` for one cycle.
  - `read_valid = 1011`.
  - `write_ready = 1` on the next cycle.
  - Pending 0x14 lands in channel 2, and `pointer` becomes 3.
- Skip full (macro undefined): with `pointer = 0`, channel 0 full and channels 1–3 empty, write 0xAA.
  - 0xAA lands in channel 1; channel 0 is untouched.
  - `pointer = 2`.
- Strict order (macro defined): the same setup as skip full.
  - `write_ready = 0` until channel 0 is read.
  - 0xAA then lands in channel 0.
- Streaming: with `read_ready = 1111`, write 12 consecutive beats 0..11.
  - Channel k outputs k, k+4, k+8.
  - One beat is accepted per cycle with no stall.
  - Each `read_valid` pulse occurs one cycle after its acceptance.
- Reset mid-operation: with 3 buffers full, drive `resetn = 0` for one edge.
  - `read_valid = 0000` and `read_data = 0`.
  - Next write goes to channel 0.
